fe_res_arbiter: RTL and testbench
=================================

Name: fe_res_arbiter

Overview:
- Shares one pipelined field-arithmetic unit (adder_pipe, subtractor_pipe or montgomery_mult_wrapper) between NUM_IN requesters, e.g. ec_fpn_dbl and ec_fe2_mul_s.
- Grants requests round-robin and stamps the requester ID into the control bits.
- Routes each unit response back to its requester by that ID.
- Bounds in-flight requests per requester with credit counters, so one stalled consumer cannot deadlock the shared pipe.

Parameters:
- NUM_IN, 3, number of requesters (2..8).
- DAT_BITS, 512, request data width (two field elements).
- RES_BITS, 256, response data width.
- CTL_BITS, 8, control sideband width.
- OVR_WRT_BIT, 6, LSB of the ID field inside ctl; ID_BITS = $clog2(NUM_IN).
- MAX_OUTST, 4, maximum in-flight requests per requester.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-low.
- i_req_val  in  NUM_IN  per-requester request valid.
- i_req_dat  in  NUM_IN*DAT_BITS  request data, requester k at [k*DAT_BITS +: DAT_BITS].
- i_req_ctl  in  NUM_IN*CTL_BITS  request control.
- o_req_rdy  out  NUM_IN  per-requester request ready.
- o_unit_val  out  1  request valid to shared unit.
- o_unit_dat  out  DAT_BITS  request data to unit.
- o_unit_ctl  out  CTL_BITS  request control, ID field overwritten.
- i_unit_rdy  in  1  unit ready.
- i_unit_val  in  1  unit response valid.
- i_unit_dat  in  RES_BITS  unit response data.
- i_unit_ctl  in  CTL_BITS  unit response control, ID field intact.
- o_unit_rdy  out  1  response ready to unit.
- o_res_val  out  NUM_IN  per-requester response valid.
- o_res_dat  out  RES_BITS  response data, shared bus.
- o_res_ctl  out  CTL_BITS  response control, ID field zeroed.
- i_res_rdy  in  NUM_IN  per-requester response ready.
- o_err  out  1  sticky error (see Optional Feature).

Behaviour:
- Reset (i_rst==0 at a rising edge):
  - o_unit_val=0, o_res_val=0, o_req_rdy=0, o_err=0.
  - All credit counters=0; RR pointer=0.
  - Reset mid-transfer drops all state; in-flight unit responses arriving after reset are still routed by ID but do not decrement credits below 0.
- Request side: a single output register with 2-state FSM IDLE/HOLD.
  - IDLE: eligible(k) = i_req_val[k] && cnt[k]<MAX_OUTST.
  - IDLE: grant the first eligible requester at or after the RR pointer.
  - IDLE, on grant: o_req_rdy[grant]=1 combinationally (only that bit), capture dat/ctl and set o_unit_ctl[OVR_WRT_BIT+:ID_BITS]=grant.
  - IDLE, on grant: o_unit_val=1 next cycle, pointer=grant+1 mod NUM_IN, go HOLD.
  - HOLD: o_unit_* stable while !i_unit_rdy; all o_req_rdy=0.
  - HOLD, on i_unit_rdy: return to IDLE, or grant again in the same cycle (back-to-back, 1 request/cycle sustained).
  - Request latency: 1 cycle from accept to o_unit_val.
- Credits:
  - cnt[k]++ on grant to k; cnt[k]-- on response handshake to k.
  - Both in the same cycle leaves cnt[k] unchanged.
  - A requester at MAX_OUTST is skipped; other requesters are unaffected.
- Response side: combinational, zero latency.
  - id = i_unit_ctl[OVR_WRT_BIT+:ID_BITS].
  - o_res_val[id] = i_unit_val; all other o_res_val bits = 0.
  - o_res_dat = i_unit_dat; o_res_ctl = i_unit_ctl with the ID field zeroed.
  - o_unit_rdy = i_res_rdy[id]. Backpressure from requester id stalls the unit output only.
- Requester ctl bits at the ID field position are clobbered; requesters keep them zero.

Optional Feature:
- Macro: FE_RES_ARBITER_CHECK_EN.
- Defined:
  - o_err sets (sticky until reset) on a response handshake with id>=NUM_IN or with cnt[id]==0.
  - An id>=NUM_IN response is accepted (o_unit_rdy=1) and discarded.
  - Overflow of any cnt past MAX_OUTST also sets o_err.
- Undefined:
  - o_err is tied 0.
  - An id>=NUM_IN response is still accepted and discarded.
  - No check logic is synthesised.

Test Plan:
- Reset, then i_req_val=3'b111 held, i_unit_rdy=1, unit loopback with 2-cycle latency, all i_res_rdy=1.
  - Grants go 0,1,2,0,1,2.
  - o_unit_ctl[7:6] follows 0,1,2.
  - Each requester receives its own result.
- Request from requester 1 with dat=A, i_unit_rdy=0 for 5 cycles.
  - o_unit_val=1 and o_unit_dat=A stable all 5 cycles.
  - o_req_rdy=0 throughout.
  - Issue on cycle 6.
- i_res_rdy[2]=0, requester 2 streams requests.
  - After 4 grants to requester 2, it is skipped while requesters 0/1 keep 1 grant/cycle.
  - Set i_res_rdy[2]=1 → requester 2 resumes after the first response drains.
- Same-cycle grant and response to requester 0 with cnt[0]=3 → cnt[0] stays 3; no spurious stall.
- i_rst=0 asserted during HOLD.
  - Next cycle o_unit_val=0 and all counters=0.
  - After release, grants restart at requester 0.
- With FE_RES_ARBITER_CHECK_EN: inject a unit response with ctl[7:6]=3 → o_err=1 from the next cycle until reset; the response is dropped. Without the macro, o_err stays 0.

Source files
------------

// File: rtl/fe_res_arbiter.sv
// Round-robin arbiter sharing one pipelined field-arithmetic unit between NUM_IN requesters,
// with ID-tagged response routing and per-requester credits. Define FE_RES_ARBITER_CHECK_EN for o_err.
module fe_res_arbiter #(
  parameter int NUM_IN      = 3,
  parameter int DAT_BITS    = 512,
  parameter int RES_BITS    = 256,
  parameter int CTL_BITS    = 8,
  parameter int OVR_WRT_BIT = 6,
  parameter int MAX_OUTST   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_IN-1:0]            i_req_val,
  input  logic [NUM_IN*DAT_BITS-1:0]   i_req_dat,
  input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
  output logic [NUM_IN-1:0]            o_req_rdy,
  output logic                         o_unit_val,
  output logic [DAT_BITS-1:0]          o_unit_dat,
  output logic [CTL_BITS-1:0]          o_unit_ctl,
  input  logic                         i_unit_rdy,
  input  logic                         i_unit_val,
  input  logic [RES_BITS-1:0]          i_unit_dat,
  input  logic [CTL_BITS-1:0]          i_unit_ctl,
  output logic                         o_unit_rdy,
  output logic [NUM_IN-1:0]            o_res_val,
  output logic [RES_BITS-1:0]          o_res_dat,
  output logic [CTL_BITS-1:0]          o_res_ctl,
  input  logic [NUM_IN-1:0]            i_res_rdy,
  output logic                         o_err
);

  localparam int ID_BITS  = $clog2(NUM_IN);
  localparam int CNT_BITS = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_BITS-1:0] LP_MAX     = CNT_BITS'(MAX_OUTST);
  localparam logic [CNT_BITS-1:0] LP_CNT_ONE = CNT_BITS'(1);
  localparam logic [ID_BITS:0]    LP_NUM     = (ID_BITS+1)'(NUM_IN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]          r_state;
  logic [ID_BITS-1:0]  r_ptr;
  logic [CNT_BITS-1:0] r_cnt [NUM_IN];
  logic [DAT_BITS-1:0] r_unit_dat;
  logic [CTL_BITS-1:0] r_unit_ctl;

  logic [NUM_IN-1:0]   w_elig;
  logic [NUM_IN-1:0]   w_inc;
  logic [NUM_IN-1:0]   w_dec;
  logic                w_can_load;
  logic                w_grant_v;
  logic [ID_BITS-1:0]  w_grant_id;
  logic [ID_BITS-1:0]  w_cand;
  logic [ID_BITS-1:0]  w_ptr_nxt;
  logic [DAT_BITS-1:0] w_sel_dat;
  logic [CTL_BITS-1:0] w_sel_ctl;
  logic [ID_BITS-1:0]  w_rsp_id;
  logic                w_rsp_ok;
  logic                w_rsp_hs;

  // Wraps a requester index in [0, 2*NUM_IN) back into [0, NUM_IN).
  function automatic logic [ID_BITS-1:0] f_wrap(input logic [ID_BITS:0] v);
    return (v >= LP_NUM) ? ID_BITS'(v - LP_NUM) : v[ID_BITS-1:0];
  endfunction

  // The output register can take a new request when empty or when it drains this cycle.
  assign w_can_load = (r_state == ST_IDLE) || i_unit_rdy;

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      w_elig[k] = i_req_val[k] && (r_cnt[k] < LP_MAX);
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise paths that skip it infer latches.
  always_comb begin
    w_grant_v  = 1'b0;
    w_grant_id = '0;
    w_cand     = '0;
    if (i_rst && w_can_load) begin
      for (int i = 0; i < NUM_IN; i++) begin
        w_cand = f_wrap({1'b0, r_ptr} + (ID_BITS+1)'(i));
        if (!w_grant_v && w_elig[w_cand]) begin
          w_grant_v  = 1'b1;
          w_grant_id = w_cand;
        end
      end
    end
  end

  assign w_ptr_nxt = f_wrap({1'b0, w_grant_id} + (ID_BITS+1)'(1));

  always_comb begin
    o_req_rdy = '0;
    if (w_grant_v) o_req_rdy[w_grant_id] = 1'b1;
  end

  always_comb begin
    w_sel_dat = '0;
    w_sel_ctl = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_grant_id == ID_BITS'(k)) begin
        w_sel_dat = i_req_dat[k*DAT_BITS +: DAT_BITS];
        w_sel_ctl = i_req_ctl[k*CTL_BITS +: CTL_BITS];
      end
    end
    w_sel_ctl[OVR_WRT_BIT +: ID_BITS] = w_grant_id;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else if (w_grant_v) begin
      r_state <= ST_HOLD;
      r_ptr   <= w_ptr_nxt;
    end else if (i_unit_rdy) begin
      r_state <= ST_IDLE;
    end
  end

  // NOTE: payload registers carry no reset; o_unit_val qualifies them, so reset only costs routing.
  always_ff @(posedge i_clk) begin
    if (w_grant_v) begin
      r_unit_dat <= w_sel_dat;
      r_unit_ctl <= w_sel_ctl;
    end
  end

  assign o_unit_val = (r_state == ST_HOLD);
  assign o_unit_dat = r_unit_dat;
  assign o_unit_ctl = r_unit_ctl;

  // Response routing is purely combinational; unknown IDs are swallowed rather than stalling the unit.
  assign w_rsp_id = i_unit_ctl[OVR_WRT_BIT +: ID_BITS];
  assign w_rsp_ok = ({1'b0, w_rsp_id} < LP_NUM);

  always_comb begin
    o_res_val  = '0;
    o_unit_rdy = 1'b0;
    if (i_rst) begin
      if (w_rsp_ok) begin
        o_res_val[w_rsp_id] = i_unit_val;
        o_unit_rdy          = i_res_rdy[w_rsp_id];
      end else begin
        o_unit_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    o_res_ctl = i_unit_ctl;
    o_res_ctl[OVR_WRT_BIT +: ID_BITS] = '0;
  end

  assign o_res_dat = i_unit_dat;
  assign w_rsp_hs  = i_unit_val && o_unit_rdy;

  // Stray responses after a reset must not wrap a credit below zero.
  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      w_inc[k] = w_grant_v && (w_grant_id == ID_BITS'(k));
      w_dec[k] = w_rsp_hs && w_rsp_ok && (w_rsp_id == ID_BITS'(k)) && (r_cnt[k] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_IN; k++) begin
      if (!i_rst) begin
        r_cnt[k] <= '0;
      end else begin
        case ({w_inc[k], w_dec[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + LP_CNT_ONE;
          2'b01:   r_cnt[k] <= r_cnt[k] - LP_CNT_ONE;
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

`ifdef FE_RES_ARBITER_CHECK_EN
  logic r_err;
  logic w_cnt_zero;
  logic w_ovf;

  always_comb begin
    w_cnt_zero = 1'b0;
    w_ovf      = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_rsp_id == ID_BITS'(k)) w_cnt_zero = (r_cnt[k] == '0);
      if (w_inc[k] && !w_dec[k] && (r_cnt[k] == LP_MAX)) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_err <= 1'b0;
    end else if ((w_rsp_hs && (!w_rsp_ok || w_cnt_zero)) || w_ovf) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fe_res_arbiter.sv
// Self-checking bench for fe_res_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model (round-robin over int credits, per-requester expected-result queues).
module tb_fe_res_arbiter;

  localparam int N  = 3;
  localparam int DW = 512;
  localparam int RW = 256;
  localparam int CW = 8;
  localparam int OB = 6;
  localparam int IB = 2;
  localparam int MO = 4;
  localparam logic [CW-1:0] ID_MASK = CW'(((1 << IB) - 1) << OB);
`ifdef FE_RES_ARBITER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [RW-1:0] dat;
    logic [CW-1:0] ctl;
  } res_t;

  typedef struct {
    logic [RW-1:0] dat;
    logic [CW-1:0] ctl;
    int            ready;
  } uq_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_val;
  logic [N*DW-1:0] req_dat;
  logic [N*CW-1:0] req_ctl;
  logic [N-1:0]    req_rdy;
  logic            unit_val_o;
  logic [DW-1:0]   unit_dat_o;
  logic [CW-1:0]   unit_ctl_o;
  logic            unit_rdy;
  logic            u_val;
  logic [RW-1:0]   u_dat;
  logic [CW-1:0]   u_ctl;
  logic            unit_rdy_o;
  logic [N-1:0]    res_val;
  logic [RW-1:0]   res_dat;
  logic [CW-1:0]   res_ctl;
  logic [N-1:0]    res_rdy;
  logic            err;

  fe_res_arbiter #(
    .NUM_IN(N), .DAT_BITS(DW), .RES_BITS(RW), .CTL_BITS(CW), .OVR_WRT_BIT(OB), .MAX_OUTST(MO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_val(req_val), .i_req_dat(req_dat), .i_req_ctl(req_ctl), .o_req_rdy(req_rdy),
    .o_unit_val(unit_val_o), .o_unit_dat(unit_dat_o), .o_unit_ctl(unit_ctl_o), .i_unit_rdy(unit_rdy),
    .i_unit_val(u_val), .i_unit_dat(u_dat), .i_unit_ctl(u_ctl), .o_unit_rdy(unit_rdy_o),
    .o_res_val(res_val), .o_res_dat(res_dat), .o_res_ctl(res_ctl), .i_res_rdy(res_rdy),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 2;
  bit inj   = 1'b0;

  // reference model state
  int            m_ptr = 0;
  int            m_cnt [N];
  bit            m_hold = 1'b0;
  int            m_hid = 0;
  logic [DW-1:0] m_hdat;
  logic [CW-1:0] m_hctl;
  logic          m_err = 1'b0;
  res_t          q_res [N][$];
  uq_t           uq [$];

  // values observed at the last mid-cycle sample
  logic [N-1:0]  ob_req_rdy;
  logic          ob_unit_val;
  logic [DW-1:0] ob_unit_dat;
  logic [CW-1:0] ob_unit_ctl;
  logic          ob_unit_rdy;
  logic [N-1:0]  ob_res_val;
  logic          ob_err;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] f_res(input logic [DW-1:0] d);
    return d[RW-1:0] ^ d[DW-1:RW];
  endfunction

  function automatic logic [DW-1:0] rnd_dat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [RW-1:0] rnd_res();
    logic [RW-1:0] v;
    for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_reqs(input logic [N-1:0] v);
    req_val = v;
    for (int k = 0; k < N; k++) begin
      req_dat[k*DW +: DW] = rnd_dat();
      req_ctl[k*CW +: CW] = CW'($urandom) & ~ID_MASK;
    end
  endtask

  function automatic bit model_idle();
    bit e = !m_hold && (uq.size() == 0);
    for (int k = 0; k < N; k++) if (q_res[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  // One clock: drive the unit's response side, sample mid-cycle, check, advance the model.
  task automatic cycle();
    int            grant;
    int            id;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_rv;
    logic          exp_urdy;
    logic          hs;
    logic [DW-1:0] d;
    res_t          r;
    uq_t           u;

    if (!inj) begin
      if (uq.size() > 0 && uq[0].ready <= cyc) begin
        u_val = 1'b1; u_dat = uq[0].dat; u_ctl = uq[0].ctl;
      end else begin
        u_val = 1'b0; u_dat = rnd_res(); u_ctl = CW'($urandom);
      end
    end
    @(negedge clk);
    ob_req_rdy = req_rdy; ob_unit_val = unit_val_o; ob_unit_dat = unit_dat_o;
    ob_unit_ctl = unit_ctl_o; ob_unit_rdy = unit_rdy_o; ob_res_val = res_val; ob_err = err;

    grant = -1;
    if (rst && (!m_hold || unit_rdy)) begin
      for (int i = 0; i < N; i++) begin
        int k = (m_ptr + i) % N;
        if (grant < 0 && req_val[k] && m_cnt[k] < MO) grant = k;
      end
    end
    exp_rdy = '0;
    if (grant >= 0) exp_rdy[grant] = 1'b1;
    id = int'(u_ctl[OB +: IB]);
    exp_rv = '0;
    exp_urdy = 1'b0;
    if (rst) begin
      if (id < N) begin exp_rv[id] = u_val; exp_urdy = res_rdy[id]; end
      else exp_urdy = 1'b1;
    end
    hs = u_val && exp_urdy;

    check("req_rdy", ob_req_rdy, exp_rdy);
    check("unit_val", ob_unit_val, m_hold);
    if (m_hold) begin
      check("unit_dat", ob_unit_dat, m_hdat);
      check("unit_ctl", ob_unit_ctl, m_hctl);
    end
    check("res_val", ob_res_val, exp_rv);
    check("unit_rdy", ob_unit_rdy, exp_urdy);
    check("err", ob_err, m_err);
    if (hs && id < N) begin
      check("res_pending", q_res[id].size() > 0, 1);
      if (q_res[id].size() > 0) begin
        r = q_res[id].pop_front();
        check("res_dat", res_dat, r.dat);
        check("res_ctl", res_ctl, r.ctl);
      end
    end

    if (CHK && hs && (id >= N || m_cnt[id] == 0)) m_err = 1'b1;
    if (!rst) begin
      if (m_hold && !unit_rdy) void'(q_res[m_hid].pop_back());
      m_hold = 1'b0; m_ptr = 0; m_err = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (grant == k) m_cnt[k]++;
        if (hs && id == k && m_cnt[k] > 0 && grant != k) m_cnt[k]--;
        else if (hs && id == k && grant == k && m_cnt[k] > 1) m_cnt[k]--;
      end
      if (grant >= 0) begin
        d = req_dat[grant*DW +: DW];
        m_hold = 1'b1; m_hid = grant; m_hdat = d;
        m_hctl = req_ctl[grant*CW +: CW];
        m_hctl[OB +: IB] = IB'(grant);
        m_ptr = (grant + 1) % N;
        r.dat = f_res(d); r.ctl = req_ctl[grant*CW +: CW];
        q_res[grant].push_back(r);
      end else if (unit_rdy) begin
        m_hold = 1'b0;
      end
    end

    if (!inj && u_val && unit_rdy_o) void'(uq.pop_front());
    if (unit_val_o && unit_rdy) begin
      u.dat = f_res(unit_dat_o); u.ctl = unit_ctl_o; u.ready = cyc + lat;
      uq.push_back(u);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b = 0;
    bit done;
    rst = 1'b1; req_val = '0; unit_rdy = 1'b1; res_rdy = '1;
    done = model_idle();
    while (!done && b < 200) begin
      cycle();
      b++;
      done = model_idle();
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]  e;
    logic [DW-1:0] a;
    int            n;
    bit            seen;

    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    rst = 1'b0; req_val = '0; req_dat = '0; req_ctl = '0;
    unit_rdy = 1'b0; res_rdy = '0; u_val = 1'b0; u_dat = '0; u_ctl = '0;
    @(posedge clk);
    #1;

    // reset state with requests pending
    drive_reqs('1);
    repeat (2) cycle();
    check("rst_err", ob_err, 0);

    // round robin over all three, 2-cycle unit loopback
    rst = 1'b1; unit_rdy = 1'b1; res_rdy = '1; lat = 2;
    for (int i = 0; i < 6; i++) begin
      drive_reqs('1);
      cycle();
      e = '0; e[i % N] = 1'b1;
      check("rr_grant", ob_req_rdy, e);
      if (i > 0) check("rr_id", ob_unit_ctl[OB +: IB], (i - 1) % N);
    end
    repeat (12) begin drive_reqs('1); cycle(); end
    drain();

    // held request while the unit stalls
    a = rnd_dat();
    req_val = 3'b010; req_dat[DW +: DW] = a; req_ctl[CW +: CW] = '0; unit_rdy = 1'b0;
    cycle();
    check("hold_accept", ob_req_rdy, 3'b010);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_val", ob_unit_val, 1);
      check("hold_dat", ob_unit_dat, a);
      check("hold_rdy", ob_req_rdy, 0);
    end
    unit_rdy = 1'b1; req_val = '0;
    cycle();
    check("hold_issue", ob_unit_val, 1);
    drain();

    // credit cap on a backpressured requester
    res_rdy = 3'b011; unit_rdy = 1'b1; lat = 2; n = 0;
    repeat (10) begin drive_reqs(3'b100); cycle(); n += int'(ob_req_rdy[2]); end
    check("cred_cap", n, MO);
    repeat (6) begin
      drive_reqs('1);
      cycle();
      check("cred_skip2", ob_req_rdy[2], 0);
      check("cred_others", |ob_req_rdy, 1);
    end
    res_rdy = '1; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      drive_reqs('1);
      cycle();
      seen = ob_req_rdy[2];
    end
    check("cred_resume", seen, 1);
    drain();

    // steady stream: grant and response to requester 0 coincide at cnt=3
    lat = 2;
    for (int i = 0; i < 12; i++) begin
      drive_reqs(3'b001);
      cycle();
      check("same_cycle", ob_req_rdy, 3'b001);
    end
    drain();

    // reset while HOLD, with requester 0 saturated
    res_rdy = '0; unit_rdy = 1'b1;
    repeat (8) begin drive_reqs(3'b001); cycle(); end
    check("sat0", ob_req_rdy[0], 0);
    drive_reqs(3'b010); unit_rdy = 1'b0;
    cycle();
    rst = 1'b0; drive_reqs('0);
    cycle();
    rst = 1'b1; unit_rdy = 1'b1; drive_reqs('1);
    cycle();
    check("rst_unit_val", ob_unit_val, 0);
    check("rst_restart", ob_req_rdy, 3'b001);
    drain();

    // response with an out-of-range ID
    rst = 1'b0; drive_reqs('0);
    cycle();
    rst = 1'b1;
    inj = 1'b1; u_val = 1'b1; u_dat = rnd_res();
    u_ctl = (CW'($urandom) & ~ID_MASK) | ID_MASK; res_rdy = '0;
    cycle();
    check("inj_unit_rdy", ob_unit_rdy, 1);
    check("inj_res_val", ob_res_val, 0);
    inj = 1'b0; res_rdy = '1;
    cycle();
    check("inj_err", ob_err, CHK);
    repeat (3) cycle();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom % 300) != 0;
      drive_reqs(N'($urandom));
      unit_rdy = ($urandom % 4) != 0;
      for (int k = 0; k < N; k++) res_rdy[k] = ($urandom % 4) != 0;
      lat = 1 + int'($urandom % 4);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
